// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer that shares one ALU between two requesters.
// One operation in flight: accept, drive ALU for L cycles, capture, respond.
module alu_arbiter #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [1:0]     req_mode,
    input  logic [7:0]     req_cmd,
    input  logic [3:0]     req_in_valid,
    input  logic [2*W-1:0] req_opa,
    input  logic [2*W-1:0] req_opb,
    input  logic [1:0]     req_cin,
    output logic           alu_ce,
    output logic           alu_mode,
    output logic [3:0]     alu_cmd,
    output logic [1:0]     alu_in_valid,
    output logic [W-1:0]   alu_opa,
    output logic [W-1:0]   alu_opb,
    output logic           alu_cin,
    input  logic [W:0]     alu_res,
    input  logic           alu_err,
    input  logic           alu_of,
    input  logic           alu_cout,
    input  logic           alu_g,
    input  logic           alu_l,
    input  logic           alu_e,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W:0]     rsp_res,
    output logic           rsp_err,
    output logic           rsp_of,
    output logic           rsp_cout,
    output logic           rsp_g,
    output logic           rsp_l,
    output logic           rsp_e,
    output logic           busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_CAPT,
        S_RESP
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic         r_last;
    logic [1:0]   r_cnt;

    logic         r_mode;
    logic [3:0]   r_cmd;
    logic [1:0]   r_in_valid;
    logic [W-1:0] r_opa;
    logic [W-1:0] r_opb;
    logic         r_cin;

    logic         r_id;
    logic [W:0]   r_res;
    logic [5:0]   r_flags;

    logic         w_win;
    logic         w_take;
    logic         w_mode;
    logic [3:0]   w_cmd;
    logic [1:0]   w_in_valid;
    logic [W-1:0] w_opa;
    logic [W-1:0] w_opb;
    logic         w_cin;
    logic [1:0]   w_lat;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        w_win = 1'b0;
        unique case (req_valid)
            2'b01:   w_win = 1'b0;
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = ~r_last;
            default: w_win = 1'b0;
        endcase
    end

    assign w_take = (r_state == S_IDLE) && (req_valid != 2'b00) && !rst;

    assign req_ready = w_take ? (w_win ? 2'b10 : 2'b01) : 2'b00;

    assign w_mode     = w_win ? req_mode[1] : req_mode[0];
    assign w_cmd      = w_win ? req_cmd[7:4] : req_cmd[3:0];
    assign w_in_valid = w_win ? req_in_valid[3:2] : req_in_valid[1:0];
    assign w_opa      = w_win ? req_opa[2*W-1:W] : req_opa[W-1:0];
    assign w_opb      = w_win ? req_opb[2*W-1:W] : req_opb[W-1:0];
    assign w_cin      = w_win ? req_cin[1] : req_cin[0];

    // Multiplies go through the ALU's extra result stage.
    assign w_lat = (w_mode && (w_cmd == 4'b1001 || w_cmd == 4'b1010))
                 ? 2'd3 : 2'd2;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_take) w_next = S_EXEC;
            S_EXEC: if (r_cnt == 2'd1) w_next = S_CAPT;
            S_CAPT: w_next = S_RESP;
            S_RESP: if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
            r_cnt  <= 2'd0;
            r_id   <= 1'b0;
        end else if (w_take) begin
            r_last <= w_win;
            r_cnt  <= w_lat;
            r_id   <= w_win;
        end else if (r_state == S_EXEC) begin
            r_cnt <= r_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= 1'b0;
            r_cmd      <= 4'd0;
            r_in_valid <= 2'd0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_cin      <= 1'b0;
        end else if (w_take) begin
            r_mode     <= w_mode;
            r_cmd      <= w_cmd;
            r_in_valid <= w_in_valid;
            r_opa      <= w_opa;
            r_opb      <= w_opb;
            r_cin      <= w_cin;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res   <= '0;
            r_flags <= 6'd0;
        end else if (r_state == S_CAPT) begin
            r_res   <= alu_res;
            r_flags <= {alu_err, alu_of, alu_cout, alu_g, alu_l, alu_e};
        end
    end

    assign alu_ce       = (r_state == S_EXEC);
    assign alu_mode     = r_mode;
    assign alu_cmd      = r_cmd;
    assign alu_in_valid = r_in_valid;
    assign alu_opa      = r_opa;
    assign alu_opb      = r_opb;
    assign alu_cin      = r_cin;

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_id;
    assign rsp_res   = r_res;
    assign {rsp_err, rsp_of, rsp_cout, rsp_g, rsp_l, rsp_e} = r_flags;

    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stand-in, directed steps, then
// randomized operations checked against a grant/latency/result model.
module tb_alu_arbiter;

    localparam int W = 8;

    typedef struct packed {
        logic [8:0] res;
        logic       err;
        logic       of;
        logic       cout;
        logic       g;
        logic       l;
        logic       e;
    } out_t;

    logic         clk;
    logic         rst;
    logic [1:0]   v;
    logic         m  [2];
    logic [3:0]   c  [2];
    logic [1:0]   iv [2];
    logic [7:0]   a  [2];
    logic [7:0]   b  [2];
    logic         ci [2];

    logic [1:0]   req_ready;
    logic [1:0]   req_mode;
    logic [7:0]   req_cmd;
    logic [3:0]   req_in_valid;
    logic [15:0]  req_opa;
    logic [15:0]  req_opb;
    logic [1:0]   req_cin;
    logic         alu_ce;
    logic         alu_mode;
    logic [3:0]   alu_cmd;
    logic [1:0]   alu_in_valid;
    logic [7:0]   alu_opa;
    logic [7:0]   alu_opb;
    logic         alu_cin;
    logic [8:0]   alu_res;
    logic         alu_err, alu_of, alu_cout, alu_g, alu_l, alu_e;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [8:0]   rsp_res;
    logic         rsp_err, rsp_of, rsp_cout, rsp_g, rsp_l, rsp_e;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int last_g = 1;

    assign req_mode     = {m[1], m[0]};
    assign req_cmd      = {c[1], c[0]};
    assign req_in_valid = {iv[1], iv[0]};
    assign req_opa      = {a[1], a[0]};
    assign req_opb      = {b[1], b[0]};
    assign req_cin      = {ci[1], ci[0]};

    alu_arbiter #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(v), .req_ready(req_ready),
        .req_mode(req_mode), .req_cmd(req_cmd),
        .req_in_valid(req_in_valid),
        .req_opa(req_opa), .req_opb(req_opb), .req_cin(req_cin),
        .alu_ce(alu_ce), .alu_mode(alu_mode), .alu_cmd(alu_cmd),
        .alu_in_valid(alu_in_valid),
        .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cin(alu_cin),
        .alu_res(alu_res), .alu_err(alu_err), .alu_of(alu_of),
        .alu_cout(alu_cout), .alu_g(alu_g), .alu_l(alu_l), .alu_e(alu_e),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_err(rsp_err), .rsp_of(rsp_of),
        .rsp_cout(rsp_cout), .rsp_g(rsp_g), .rsp_l(rsp_l), .rsp_e(rsp_e),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in: logic ops and add/sub/compare, plus two multiplies.
    function automatic out_t alu_f(input logic md, input logic [3:0] cm,
                                   input logic [1:0] iva, input logic [7:0] x,
                                   input logic [7:0] y, input logic cy);
        out_t o;
        int   s;
        o = '0;
        s = 0;
        if (iva != 2'b11) begin
            o.err = 1'b1;
            return o;
        end
        if (md) begin
            case (cm)
                4'd0: s = int'(x) + int'(y);
                4'd1: s = int'(x) - int'(y);
                4'd2: s = int'(x) + int'(y) + int'(cy);
                4'd8: begin
                    o.g = (x > y);
                    o.l = (x < y);
                    o.e = (x == y);
                end
                4'd9:  s = (int'(x) + 1) * (int'(y) + 1);
                4'd10: s = (int'(x) * 2) * int'(y);
                default: o.err = 1'b1;
            endcase
            o.res = s[8:0];
            if (cm == 4'd0 || cm == 4'd2) o.cout = s[8];
            if (cm == 4'd1) o.of = (x < y);
        end else begin
            case (cm)
                4'd0: o.res = {1'b0, x & y};
                4'd1: o.res = {1'b0, ~(x & y)};
                4'd2: o.res = {1'b0, x | y};
                4'd3: o.res = {1'b0, ~(x | y)};
                4'd4: o.res = {1'b0, x ^ y};
                4'd5: o.res = {1'b0, ~(x ^ y)};
                4'd6: o.res = {1'b0, ~x};
                default: o.err = 1'b1;
            endcase
        end
        return o;
    endfunction

    out_t p0, p1, p2;
    logic w_mul;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p0 <= '0;
            p1 <= '0;
            p2 <= '0;
        end else if (alu_ce) begin
            p0 <= alu_f(alu_mode, alu_cmd, alu_in_valid,
                        alu_opa, alu_opb, alu_cin);
            p1 <= p0;
            p2 <= p1;
        end
    end

    assign w_mul = alu_mode && (alu_cmd == 4'd9 || alu_cmd == 4'd10);
    assign {alu_res, alu_err, alu_of, alu_cout, alu_g, alu_l, alu_e} =
        w_mul ? p2 : p1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic md, input logic [3:0] cm,
                           input logic [1:0] iva, input logic [7:0] x,
                           input logic [7:0] y, input logic cy);
        m[i]  = md;
        c[i]  = cm;
        iv[i] = iva;
        a[i]  = x;
        b[i]  = y;
        ci[i] = cy;
    endtask

    // Called at a negedge in IDLE with v != 0; returns at a negedge in IDLE.
    task automatic op(input int hold, output int win, output out_t got);
        out_t exp;
        int   lat, n, ce;
        logic bad_rdy, bad_opnd, bad_hold;
        #1;
        if (v == 2'b11) win = (last_g == 0) ? 1 : 0;
        else            win = v[1] ? 1 : 0;
        chk("req_ready", 32'(req_ready), (win == 1) ? 32'd2 : 32'd1);
        exp = alu_f(m[win], c[win], iv[win], a[win], b[win], ci[win]);
        lat = (m[win] && (c[win] == 4'd9 || c[win] == 4'd10)) ? 3 : 2;
        @(posedge clk);
        last_g = win;
        @(negedge clk);
        if (hold > 0) rsp_ready = 1'b0;
        n = 1;
        ce = 0;
        bad_rdy = 1'b0;
        bad_opnd = 1'b0;
        while (!rsp_valid && n < 12) begin
            if (alu_ce) begin
                ce++;
                if ({alu_mode, alu_cmd, alu_in_valid, alu_opa, alu_opb,
                     alu_cin} !== {m[win], c[win], iv[win], a[win], b[win],
                     ci[win]})
                    bad_opnd = 1'b1;
            end
            if (req_ready !== 2'b00 || busy !== 1'b1) bad_rdy = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(lat + 2));
        chk("ce_cycles", 32'(ce), 32'(lat));
        chk("alu_operands", 32'(bad_opnd), 32'd0);
        chk("busy_noready", 32'(bad_rdy), 32'd0);
        got = {rsp_res, rsp_err, rsp_of, rsp_cout, rsp_g, rsp_l, rsp_e};
        chk("rsp_id", 32'(rsp_id), 32'(win));
        chk("rsp_data", 32'(got), 32'(exp));
        bad_hold = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || req_ready !== 2'b00
                || rsp_id !== 1'(win)
                || {rsp_res, rsp_err, rsp_of, rsp_cout, rsp_g, rsp_l,
                    rsp_e} !== got)
                bad_hold = 1'b1;
        end
        if (hold > 0) chk("rsp_hold", 32'(bad_hold), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rsp_drop", 32'({rsp_valid, busy}), 32'd0);
        @(negedge clk);
    endtask

    int   w;
    out_t r;

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        v = 2'b11;
        set_req(0, 1'b0, 4'd0, 2'b11, 8'hFF, 8'h0F, 1'b0);
        set_req(1, 1'b0, 4'd4, 2'b11, 8'hF0, 8'h0F, 1'b0);
        #2;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_alu", 32'({alu_ce, alu_mode, alu_cmd, alu_in_valid,
                            alu_opa, alu_opb, alu_cin}), 32'd0);
        chk("rst_rsp", 32'({rsp_valid, rsp_id, rsp_res, rsp_err, rsp_of,
                            rsp_cout, rsp_g, rsp_l, rsp_e, busy}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Tie from reset, rsp_ready held high: grants alternate from 0.
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op(0, w, r);
            chk("tie_win", 32'(w), 32'(i % 2));
            chk("tie_res", 32'(r.res), (i % 2 == 0) ? 32'h0F : 32'hFF);
        end
        v = 2'b00;
        rsp_ready = 1'b0;
        @(negedge clk);

        set_req(0, 1'b1, 4'd0, 2'b11, 8'd200, 8'd100, 1'b0);
        v = 2'b01;
        op(0, w, r);
        chk("add_res", 32'(r.res), 32'h12C);
        chk("add_cout", 32'(r.cout), 32'd1);

        set_req(1, 1'b1, 4'd9, 2'b11, 8'd3, 8'd4, 1'b0);
        v = 2'b10;
        op(0, w, r);
        chk("mul_res", 32'(r.res), 32'd20);
        chk("mul_id", 32'(w), 32'd1);

        set_req(0, 1'b1, 4'd1, 2'b11, 8'd5, 8'd9, 1'b0);
        v = 2'b11;
        op(5, w, r);

        set_req(0, 1'b1, 4'd0, 2'b01, 8'd7, 8'd9, 1'b0);
        v = 2'b01;
        op(0, w, r);
        chk("err_flag", 32'(r.err), 32'd1);
        chk("err_res", 32'(r.res), 32'd0);

        // Reset one cycle after an accept by requester 0.
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 4'd0, 2'b11, 8'd1, 8'd2, 1'b0);
        v = 2'b01;
        #1;
        chk("mid_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst", 32'({busy, alu_ce, rsp_valid, req_ready}), 32'd0);
        chk("mid_opa", 32'(alu_opa), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_g = 1;
        v = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("mid_quiet", 32'({busy, rsp_valid}), 32'd0);
        v = 2'b11;
        op(0, w, r);
        chk("post_rst_win", 32'(w), 32'd0);

        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 2; i++) begin
                set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                        ($urandom_range(0, 3) == 0)
                            ? 2'($urandom_range(0, 3)) : 2'b11,
                        8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            end
            v = 2'($urandom_range(1, 3));
            rsp_ready = 1'($urandom_range(0, 1));
            op($urandom_range(0, 3), w, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
